// File: rtl/jtpang_kabuki_pkg.sv
// rtl/jtpang_kabuki_pkg.sv - shared constants, pipeline types and bit-permutation helpers for the kabuki decryptor
package jtpang_kabuki_pkg;

    // header byte positions within the ROM-load key block
    localparam logic [3:0] HDR_EN  = 4'd0;
    localparam logic [3:0] HDR_SK1 = 4'd1;
    localparam logic [3:0] HDR_SK2 = 4'd5;
    localparam logic [3:0] HDR_AK  = 4'd9;
    localparam logic [3:0] HDR_XK  = 4'd11;

    // data reads use a scrambled address in the select computation
    localparam logic [15:0] SEL_XOR = 16'h1fc0;

    // stage-1 register contents; addr/m1_n let the output check which access a byte belongs to
    typedef struct packed {
        logic        valid;
        logic        pass;
        logic        m1_n;
        logic [15:0] addr;
        logic [15:0] sel;
        logic [7:0]  data;
    } stage_t;

    // each key nibble names a select bit; when set, swap data bit pair (2k, 2k+1)
    function automatic logic [7:0] bitswap1(input logic [15:0] key, input logic [7:0] sel,
                                            input logic [7:0] d);
        logic [7:0] r;
        r = d;
        for (int k = 0; k < 4; k++) begin
            if (sel[key[4*k +: 3]]) begin
                r[2*k]   = d[2*k+1];
                r[2*k+1] = d[2*k];
            end
        end
        return r;
    endfunction

    // same rule as bitswap1 but the pairs are walked from the top: nibble k swaps (6-2k, 7-2k)
    function automatic logic [7:0] bitswap2(input logic [15:0] key, input logic [7:0] sel,
                                            input logic [7:0] d);
        logic [7:0] r;
        r = d;
        for (int k = 0; k < 4; k++) begin
            if (sel[key[4*k +: 3]]) begin
                r[6-2*k] = d[7-2*k];
                r[7-2*k] = d[6-2*k];
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] d);
        return {d[6:0], d[7]};
    endfunction

endpackage

// File: rtl/jtpang_kabuki_key.sv
// rtl/jtpang_kabuki_key.sv - captures the kabuki enable flag and key bytes from the ROM-load header
module jtpang_kabuki_key
    import jtpang_kabuki_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        kabuki_we,
    input  logic [3:0]  ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        en,
    output logic [31:0] swap_key1,
    output logic [31:0] swap_key2,
    output logic [15:0] addr_key,
    output logic [7:0]  xor_key
);

    logic        en_q,  en_d;
    logic [31:0] sk1_q, sk1_d;
    logic [31:0] sk2_q, sk2_d;
    logic [15:0] ak_q,  ak_d;
    logic [7:0]  xk_q,  xk_d;

    // route each header byte into its key field, multi-byte keys arrive MSB first
    always_comb begin
        en_d  = en_q;
        sk1_d = sk1_q;
        sk2_d = sk2_q;
        ak_d  = ak_q;
        xk_d  = xk_q;
        if (kabuki_we) begin
            case (ioctl_addr)
                HDR_EN:          en_d         = |ioctl_dout;
                HDR_SK1:         sk1_d[31:24] = ioctl_dout;
                HDR_SK1 + 4'd1:  sk1_d[23:16] = ioctl_dout;
                HDR_SK1 + 4'd2:  sk1_d[15:8]  = ioctl_dout;
                HDR_SK1 + 4'd3:  sk1_d[7:0]   = ioctl_dout;
                HDR_SK2:         sk2_d[31:24] = ioctl_dout;
                HDR_SK2 + 4'd1:  sk2_d[23:16] = ioctl_dout;
                HDR_SK2 + 4'd2:  sk2_d[15:8]  = ioctl_dout;
                HDR_SK2 + 4'd3:  sk2_d[7:0]   = ioctl_dout;
                HDR_AK:          ak_d[15:8]   = ioctl_dout;
                HDR_AK + 4'd1:   ak_d[7:0]    = ioctl_dout;
                HDR_XK:          xk_d         = ioctl_dout;
                default: ;
            endcase
        end
    end

    // key registers, cleared on reset so the header must be downloaded again
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q  <= 1'b0;
            sk1_q <= '0;
            sk2_q <= '0;
            ak_q  <= '0;
            xk_q  <= '0;
        end else begin
            en_q  <= en_d;
            sk1_q <= sk1_d;
            sk2_q <= sk2_d;
            ak_q  <= ak_d;
            xk_q  <= xk_d;
        end
    end

    assign en        = en_q;
    assign swap_key1 = sk1_q;
    assign swap_key2 = sk2_q;
    assign addr_key  = ak_q;
    assign xor_key   = xk_q;

endmodule

// File: rtl/jtpang_kabuki.sv
// rtl/jtpang_kabuki.sv - two-stage kabuki decryptor between the main ROM slot and the Z80 data bus
module jtpang_kabuki
    import jtpang_kabuki_pkg::*;
#(
    parameter logic [15:0] ENC_LIMIT = 16'h8000,
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        kabuki_we,
    input  logic [3:0]  ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [15:0] cpu_addr,
    input  logic        m1_n,
    input  logic [7:0]  rom_data,
    input  logic        rom_ok,
    output logic [7:0]  dec_data,
    output logic        dec_ok,
    output logic        en
);

    logic [31:0] swap_key1;
    logic [31:0] swap_key2;
    logic [15:0] addr_key;
    logic [7:0]  xor_key;

    jtpang_kabuki_key u_key (
        .clk        (clk),
        .rst_n      (rst_n),
        .kabuki_we  (kabuki_we),
        .ioctl_addr (ioctl_addr),
        .ioctl_dout (ioctl_dout),
        .en         (en),
        .swap_key1  (swap_key1),
        .swap_key2  (swap_key2),
        .addr_key   (addr_key),
        .xor_key    (xor_key)
    );

    logic [15:0] base_sum;
    logic [15:0] sel;
    logic [7:0]  s1_mix;
    logic        pass;

    // select word and first half of the chain (through the xor step) for the current access
    always_comb begin
        base_sum = cpu_addr + BASE_ADDR;
        if (!m1_n) begin
            sel = base_sum + addr_key;
        end else begin
            sel = (base_sum ^ SEL_XOR) + addr_key + 16'd1;
        end
        s1_mix = rotl1(bitswap1(swap_key1[15:0], sel[7:0], rom_data));
        s1_mix = bitswap2(swap_key1[31:16], sel[7:0], s1_mix) ^ xor_key;
        pass   = ~en | (cpu_addr >= ENC_LIMIT);
    end

    stage_t s1_q, s1_d;

    // stage-1 load; a key write in progress marks the stage invalid since keys may be mid-update
    always_comb begin
        s1_d.valid = rom_ok & ~kabuki_we;
        s1_d.pass  = pass;
        s1_d.m1_n  = m1_n;
        s1_d.addr  = cpu_addr;
        s1_d.sel   = sel;
        s1_d.data  = pass ? rom_data : s1_mix;
    end

    logic [7:0]  s2_mix;
    logic [7:0]  dec_data_q, dec_data_d;
    logic        s2_valid_q, s2_valid_d;
    logic [15:0] s2_addr_q,  s2_addr_d;
    logic        s2_m1_n_q,  s2_m1_n_d;

    // second half of the chain, keyed by the high select byte captured in stage 1
    always_comb begin
        s2_mix = rotl1(s1_q.data);
        s2_mix = rotl1(bitswap2(swap_key2[15:0], s1_q.sel[15:8], s2_mix));
        s2_mix = bitswap1(swap_key2[31:16], s1_q.sel[15:8], s2_mix);
    end

    // stage-2 load; a rom_ok drop or key write kills the byte that is still in flight
    always_comb begin
        dec_data_d = s1_q.pass ? s1_q.data : s2_mix;
        s2_valid_d = s1_q.valid & rom_ok & ~kabuki_we;
        s2_addr_d  = s1_q.addr;
        s2_m1_n_d  = s1_q.m1_n;
    end

    // pipeline registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q       <= '0;
            dec_data_q <= '0;
            s2_valid_q <= 1'b0;
            s2_addr_q  <= '0;
            s2_m1_n_q  <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            dec_data_q <= dec_data_d;
            s2_valid_q <= s2_valid_d;
            s2_addr_q  <= s2_addr_d;
            s2_m1_n_q  <= s2_m1_n_d;
        end
    end

    // only flag the byte when it was decoded for exactly the access the CPU is making now
    always_comb begin
        dec_ok = rom_ok & s2_valid_q & ~kabuki_we
               & (s2_addr_q == cpu_addr) & (s2_m1_n_q == m1_n);
    end

    assign dec_data = dec_data_q;

endmodule

// File: tb/tb_jtpang_kabuki.sv
// tb/tb_jtpang_kabuki.sv - randomized self-checking bench for jtpang_kabuki against a byte-level decode model
module tb_jtpang_kabuki;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        kabuki_we;
    logic [3:0]  ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [15:0] cpu_addr;
    logic        m1_n;
    logic [7:0]  rom_data;
    logic        rom_ok;
    logic [7:0]  dec_data;
    logic        dec_ok;
    logic        en;

    int n_checks = 0;
    int n_fail   = 0;

    int m_en, m_sk1, m_sk2, m_ak, m_xk;

    jtpang_kabuki dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .kabuki_we  (kabuki_we),
        .ioctl_addr (ioctl_addr),
        .ioctl_dout (ioctl_dout),
        .cpu_addr   (cpu_addr),
        .m1_n       (m1_n),
        .rom_data   (rom_data),
        .rom_ok     (rom_ok),
        .dec_data   (dec_data),
        .dec_ok     (dec_ok),
        .en         (en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic int m_bs1(input int src, input int key, input int s);
        if ((s & (1 << ((key >> 0)  & 7))) != 0) src = (src & 'hfc) | ((src & 'h01) << 1) | ((src & 'h02) >> 1);
        if ((s & (1 << ((key >> 4)  & 7))) != 0) src = (src & 'hf3) | ((src & 'h04) << 1) | ((src & 'h08) >> 1);
        if ((s & (1 << ((key >> 8)  & 7))) != 0) src = (src & 'hcf) | ((src & 'h10) << 1) | ((src & 'h20) >> 1);
        if ((s & (1 << ((key >> 12) & 7))) != 0) src = (src & 'h3f) | ((src & 'h40) << 1) | ((src & 'h80) >> 1);
        return src;
    endfunction

    function automatic int m_bs2(input int src, input int key, input int s);
        if ((s & (1 << ((key >> 12) & 7))) != 0) src = (src & 'hfc) | ((src & 'h01) << 1) | ((src & 'h02) >> 1);
        if ((s & (1 << ((key >> 8)  & 7))) != 0) src = (src & 'hf3) | ((src & 'h04) << 1) | ((src & 'h08) >> 1);
        if ((s & (1 << ((key >> 4)  & 7))) != 0) src = (src & 'hcf) | ((src & 'h10) << 1) | ((src & 'h20) >> 1);
        if ((s & (1 << ((key >> 0)  & 7))) != 0) src = (src & 'h3f) | ((src & 'h40) << 1) | ((src & 'h80) >> 1);
        return src;
    endfunction

    function automatic int m_rot(input int src);
        return ((src & 'h7f) << 1) | ((src & 'h80) >> 7);
    endfunction

    function automatic int m_decode(input int a, input int m1n, input int src);
        int s;
        if (m_en == 0 || a >= 'h8000) return src;
        if (m1n == 0) s = (a + m_ak) & 'hffff;
        else          s = ((a ^ 'h1fc0) + m_ak + 1) & 'hffff;
        src = m_bs1(src, m_sk1 & 'hffff, s & 'hff);
        src = m_rot(src);
        src = m_bs2(src, (m_sk1 >> 16) & 'hffff, s & 'hff);
        src = src ^ m_xk;
        src = m_rot(src);
        src = m_bs2(src, m_sk2 & 'hffff, (s >> 8) & 'hff);
        src = m_rot(src);
        src = m_bs1(src, (m_sk2 >> 16) & 'hffff, (s >> 8) & 'hff);
        return src & 'hff;
    endfunction

    task automatic hdr_write(input int idx, input int b);
        kabuki_we  = 1'b1;
        ioctl_addr = 4'(idx);
        ioctl_dout = 8'(b);
        step();
        kabuki_we  = 1'b0;
        if (idx == 0)                  m_en  = (b != 0) ? 1 : 0;
        else if (idx >= 1 && idx <= 4) m_sk1 = (m_sk1 & ~('hff << (8 * (4 - idx))))  | (b << (8 * (4 - idx)));
        else if (idx >= 5 && idx <= 8) m_sk2 = (m_sk2 & ~('hff << (8 * (8 - idx))))  | (b << (8 * (8 - idx)));
        else if (idx == 9)             m_ak  = (m_ak & 'h00ff) | (b << 8);
        else if (idx == 10)            m_ak  = (m_ak & 'hff00) | b;
        else if (idx == 11)            m_xk  = b;
    endtask

    task automatic load_keys(input int enb, input int sk1, input int sk2, input int ak, input int xk);
        hdr_write(0, enb);
        for (int i = 0; i < 4; i++) hdr_write(1 + i, (sk1 >> (24 - 8 * i)) & 'hff);
        for (int i = 0; i < 4; i++) hdr_write(5 + i, (sk2 >> (24 - 8 * i)) & 'hff);
        hdr_write(9,  (ak >> 8) & 'hff);
        hdr_write(10, ak & 'hff);
        hdr_write(11, xk & 'hff);
    endtask

    task automatic access(input logic [15:0] a, input logic m, input logic [7:0] d);
        cpu_addr = a;
        m1_n     = m;
        rom_data = d;
        rom_ok   = 1'b1;
    endtask

    initial begin
        logic [15:0] a, pa;
        logic        m, pm;
        logic [7:0]  d;

        rst_n = 1'b0; kabuki_we = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
        cpu_addr = '0; m1_n = 1'b1; rom_data = '0; rom_ok = 1'b0;
        m_en = 0; m_sk1 = 0; m_sk2 = 0; m_ak = 0; m_xk = 0;
        step(); step();
        check("rst_dec_data", 32'(dec_data), 32'h0);
        check("rst_dec_ok",   32'(dec_ok),   32'h0);
        check("rst_en",       32'(en),       32'h0);

        // bypass latency with no header loaded
        rst_n = 1'b1;
        access(16'h1234, 1'b1, 8'h5a);
        #1 check("bypass_ok_e0", 32'(dec_ok), 32'h0);
        step();
        check("bypass_ok_e1", 32'(dec_ok), 32'h0);
        step();
        check("bypass_ok_e2",   32'(dec_ok),   32'h1);
        check("bypass_data_e2", 32'(dec_data), 32'h5a);
        step();
        check("bypass_data_e3", 32'(dec_data), 32'h5a);

        // all-zero keys: only the three rotations act
        load_keys(1, 0, 0, 0, 0);
        check("zero_en", 32'(en), 32'h1);
        access(16'h0000, 1'b0, 8'h81);
        step(); step();
        check("zero_ok",   32'(dec_ok),   32'h1);
        check("zero_data", 32'(dec_data), 32'h0c);

        // Pang keys, random sweep against the model
        load_keys(1, 'h01234567, 'h76543210, 'h6548, 'h24);
        pa = 16'hffff; pm = 1'b0;
        for (int i = 0; i < 400; i++) begin
            a = 16'($urandom_range(0, 'h7fff));
            if ($urandom_range(0, 15) == 0) a = a | 16'h8000;
            m = 1'($urandom_range(0, 1));
            d = 8'($urandom_range(0, 255));
            access(a, m, d);
            step();
            if (a != pa || m != pm) check("sweep_ok_early", 32'(dec_ok), 32'h0);
            step();
            check("sweep_ok",   32'(dec_ok),   32'h1);
            check("sweep_data", 32'(dec_data), 32'(m_decode(32'(a), 32'(m), 32'(d))));
            pa = a; pm = m;
        end

        // unencrypted region
        access(16'h8000, 1'b0, 8'h3c);
        step(); step();
        check("pass_ok",   32'(dec_ok),   32'h1);
        check("pass_data", 32'(dec_data), 32'h3c);

        // address change drops ok in the same cycle
        access(16'h0123, 1'b0, 8'ha7);
        step(); step();
        check("chg_a_ok", 32'(dec_ok), 32'h1);
        access(16'h0456, 1'b0, 8'h19);
        #1 check("chg_b_ok_e0", 32'(dec_ok), 32'h0);
        step();
        check("chg_b_ok_e1", 32'(dec_ok), 32'h0);
        step();
        check("chg_b_ok_e2",   32'(dec_ok),   32'h1);
        check("chg_b_data_e2", 32'(dec_data), 32'(m_decode('h456, 0, 'h19)));

        // rom_ok drop needs two fresh cycles
        rom_ok = 1'b0;
        #1 check("drop_ok_now", 32'(dec_ok), 32'h0);
        step();
        rom_ok = 1'b1;
        #1 check("drop_ok_back0", 32'(dec_ok), 32'h0);
        step();
        check("drop_ok_back1", 32'(dec_ok), 32'h0);
        step();
        check("drop_ok_back2", 32'(dec_ok), 32'h1);

        // new xor key during decode
        access(16'h2345, 1'b1, 8'h6e);
        step(); step();
        check("kw_before", 32'(dec_data), 32'(m_decode('h2345, 1, 'h6e)));
        hdr_write(11, 'h9b);
        check("kw_ok_e0", 32'(dec_ok), 32'h0);
        step();
        check("kw_ok_e1", 32'(dec_ok), 32'h0);
        step();
        check("kw_ok_e2",   32'(dec_ok),   32'h1);
        check("kw_data_e2", 32'(dec_data), 32'(m_decode('h2345, 1, 'h6e)));

        // reset mid-decode loses the keys
        rst_n = 1'b0;
        step();
        check("rst2_ok",   32'(dec_ok),   32'h0);
        check("rst2_en",   32'(en),       32'h0);
        check("rst2_data", 32'(dec_data), 32'h0);
        rst_n = 1'b1;
        m_en = 0; m_sk1 = 0; m_sk2 = 0; m_ak = 0; m_xk = 0;
        access(16'h0100, 1'b0, 8'hc5);
        step(); step();
        check("rst2_raw_ok",   32'(dec_ok),   32'h1);
        check("rst2_raw_data", 32'(dec_data), 32'hc5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jtpang_kabuki.md
Name: jtpang_kabuki

Overview:
- Kabuki opcode/data decryptor sitting between the bank-0 main ROM slot (main_data/main_ok) and the Z80 data bus.
- Captures the 11 key bytes from the ROM-load header stream (kabuki_we, ioctl_addr[3:0], ioctl_dout).
- Decodes encrypted ROM bytes through a 2-stage pipeline and re-times the slot ok flag so the CPU never sees a partially decoded byte.
- When the header enable byte is zero, data passes through with the same latency.

Parameters:
- ENC_LIMIT, 16'h8000, CPU addresses below this value are encrypted; addresses at or above it pass through.
- BASE_ADDR, 16'h0000, base_addr term added to the CPU address in select computation.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- kabuki_we  in  1  header byte write strobe
- ioctl_addr  in  4  header byte index
- ioctl_dout  in  8  header byte value
- cpu_addr  in  16  Z80 address of the current ROM access
- m1_n  in  1  low = opcode fetch
- rom_data  in  8  byte from main ROM slot
- rom_ok  in  1  slot data valid
- dec_data  out  8  decoded byte
- dec_ok  out  1  decoded byte valid for current cpu_addr/m1_n
- en  out  1  decryption enabled (header byte 0 != 0)

Behaviour:
- Reset (rst_n=0 at clk edge):
  - dec_data=0, dec_ok=0, en=0.
  - All key registers are cleared to 0.
  - The pipeline valid bits are cleared.
- Key capture, on kabuki_we only:
  - byte 0 sets en = (dout != 0).
  - bytes 1-4 load swap_key1[31:0], MSB first.
  - bytes 5-8 load swap_key2[31:0], MSB first.
  - bytes 9-10 load addr_key[15:0], MSB first.
  - byte 11 loads xor_key[7:0].
  - bytes 12-15 are ignored.
  - Keys hold their values after the download ends.
- Select computation (16-bit, wrap-around mod 2^16):
  - opcode fetch (m1_n=0): sel = cpu_addr + BASE_ADDR + addr_key.
  - data read: sel = ((cpu_addr + BASE_ADDR) ^ 16'h1fc0) + addr_key + 1.
- Decode chain, in order:
  - bitswap1(swap_key1[15:0], sel[7:0]), then rotl1.
  - bitswap2(swap_key1[31:16], sel[7:0]).
  - XOR with xor_key, then rotl1.
  - bitswap2(swap_key2[15:0], sel[15:8]), then rotl1.
  - bitswap1(swap_key2[31:16], sel[15:8]).
- bitswap1: key nibble k (bits 4k+2:4k) picks a sel bit; if that bit is 1, swap data bits (2k, 2k+1).
- bitswap2: same rule, but nibble k swaps data bits (6-2k, 7-2k).
- rotl1: rotate left by one, i.e. {d[6:0], d[7]}.
- Pipeline:
  - Stage 1 registers sel, the m1 flag, rom_data and a valid bit; it computes through the XOR step.
  - Stage 2 completes the chain and registers dec_data.
  - Latency: rom_ok=1 with stable inputs at edge N gives dec_ok=1 after edge N+2.
- Pass-through: if en=0 or cpu_addr >= ENC_LIMIT, dec_data = rom_data delayed by the same 2 stages.
- ok tracking:
  - Each stage stores the cpu_addr and m1_n it was computed for.
  - dec_ok=1 only when rom_ok=1, stage 2 valid, and the stored cpu_addr/m1_n equal the current inputs.
  - Any mismatch clears dec_ok combinationally in the same cycle; no stale byte is ever flagged valid.
- rom_ok dropping mid-pipeline: in-flight stages are invalidated and dec_ok=0 until two fresh cycles have passed.
- kabuki_we during decode: new keys take effect on the next stage-1 load, and dec_ok is forced to 0 for 2 cycles.
- Reset mid-operation: pipeline flushed, keys lost, and the header must be reloaded.

Decomposition:
- Package jtpang_kabuki_pkg holds:
  - the header byte index constants (EN=0, SK1=1, SK2=5, AK=9, XK=11);
  - the select XOR constant 16'h1fc0;
  - the bitswap1/bitswap2/rotl1 functions.
- One sub-module, jtpang_kabuki_key: header capture and key registers. The decode pipeline stays in the top module.

Test Plan:
- Reset, then en=0; rom_data=8'h5a, rom_ok=1 held 3 cycles -> dec_data=8'h5a, dec_ok rises after the 2nd edge.
- Load all keys = 0 with en byte 8'h01; m1_n=0, addr 16'h0000, rom_data=8'h81 -> dec_data=8'h0c (rotl1 applied 3 times, no swaps).
- Load the Pang keys (swap1=32'h01234567, swap2=32'h76543210, addr_key=16'h6548, xor=8'h24); sweep addresses 0-0x7fff with m1_n 0/1 -> dec_data matches the MAME kabuki_decode golden model byte for byte.
- Same keys, cpu_addr=16'h8000, rom_data=8'h3c -> dec_data=8'h3c (pass-through).
- Pipeline stable for addr A, then cpu_addr changes to B -> dec_ok=0 that same cycle and re-asserts 2 edges after B is stable with rom_ok=1.
- Pulse rst_n=0 mid-decode -> dec_ok=0 and en=0 next edge; encrypted address then returns raw data until keys are reloaded.
